binary_to_bcd_seq: RTL and testbench
====================================

Name: binary_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 ("double dabble") algorithm.
- Performs the inverse of the team's existing BCD-to-binary conversion.
- Accepts a WIDTH-bit unsigned binary value on a start pulse and produces DIGITS packed BCD digits after WIDTH shift cycles, with busy/done handshake.
- Sits between binary datapath counters and display/BCD consumers.

Parameters:
- WIDTH, 8, bit width of the unsigned binary input; legal range 4..16.
- DIGITS, 3, number of 4-bit BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1. Elaboration fails otherwise.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request conversion; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary operand; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  single-cycle pulse: bcd holds a new result.
- bcd  output  4*DIGITS  packed result; digit 0 (units) in bits [3:0], most significant digit at the top.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, bcd=0.
  - Internal shift register and counter cleared.
  - Takes priority over every other input.
- Reset mid-conversion aborts the conversion: no done pulse, and bcd returns to 0.
- States: IDLE, SHIFT. busy is high exactly when state=SHIFT.
- IDLE:
  - start=1 at edge E0 loads bin into the binary shift register.
  - BCD accumulator is cleared and counter set to WIDTH; next state is SHIFT.
  - start=0 leaves the state in IDLE.
- SHIFT, one iteration per edge:
  - Every accumulator digit >= 5 gets +3 (4-bit, no carry out of the digit).
  - Then {accumulator, binary reg} shifts left by 1.
  - Counter decrements.
- Final shift, at edge E_WIDTH:
  - The shifted accumulator is written to bcd, done<=1, next state is IDLE.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH clock cycles after the accepting edge. done stays high for exactly one cycle.
- bcd holds its value until the next completed conversion or reset. Intermediate accumulator values never appear on bcd.
- Start handling:
  - start while busy is ignored; the in-flight operand is unaffected and the request is not queued.
  - start in the cycle done=1 is accepted (state is IDLE), giving back-to-back throughput of one result per WIDTH+1 cycles.
  - start held high continuously causes a new conversion to begin on every IDLE cycle.
- Change on bin after acceptance has no effect on the current conversion.
- Arithmetic: the adjust is applied before the shift, on all DIGITS digits in parallel.
- With legal DIGITS, no digit exceeds 9 in the result, and no overflow or error output exists.

Decomposition:
- Shared package (bcd_pkg) holds:
  - state enum (IDLE, SHIFT);
  - localparam BCD_DIGIT_W = 4, ADJ_THRESH = 5, ADJ_ADD = 3;
  - function min_bcd_digits(width), used for the DIGITS legality check.
- One natural combinational sub-module: bcd_digit_adj. It takes a 4-bit digit in and returns digit+3 when >= 5, else the digit unchanged. It is instantiated DIGITS times via generate.
- FSM, counter and shift registers live in binary_to_bcd_seq.

Test Plan:
- Reset then start with bin=8'd255 → busy high for 8 cycles, done pulse 8 cycles after the start edge, bcd=12'h255 (0010_0101_0101).
- bin=8'd0 → bcd=12'h000 after 8 cycles. Then bin=8'd99 → bcd=12'h099, while the previous value 12'h000 is held until done.
- Start with bin=8'd200, pulse start again with bin=8'd7 at cycle 3 → second start ignored, result 12'h200, exactly one done.
- Start bin=8'd128, assert rst_n=0 at cycle 4 → busy=0, bcd=0, no done. Release and start bin=8'd128 → bcd=12'h128.
- start held high with bin=8'd42 then 8'd57 on consecutive accepts → results 12'h042 and 12'h057, done pulses 9 cycles apart.
- WIDTH=12, DIGITS=4, bin=12'd4095 → bcd=16'h4095 after 12 cycles. Exhaustive sweep of 0..255 at default parameters is checked against an integer model.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

  // Smallest digit count whose decimal range covers every WIDTH-bit value.
  function automatic int min_bcd_digits(input int width);
    longint unsigned max_val;
    longint unsigned pow10;
    int              n;
    max_val = (64'd1 << width) - 64'd1;
    pow10   = 64'd10;
    n       = 1;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= max_val) begin
        pow10 = pow10 * 64'd10;
        n     = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? digit_i + ADJ_ADD : digit_i;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// result published on bcd with a one-cycle done pulse.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int                ACC_W    = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

  if (WIDTH < 4 || WIDTH > 16 || DIGITS < min_bcd_digits(WIDTH)) begin : g_param_err
    $error("binary_to_bcd_seq: illegal WIDTH/DIGITS combination");
  end

  state_e              state_q;
  logic [WIDTH-1:0]    bin_q;
  logic [WIDTH-1:0]    bin_d;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    acc_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [ACC_W-1:0]    bcd_q;
  logic                busy_q;
  logic                done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjust first, then shift the operand MSB into the accumulator.
  assign acc_d = {acc_adj[ACC_W-2:0], bin_q[WIDTH-1]};
  assign bin_d = {bin_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= bin;
            acc_q   <= '0;
            cnt_q   <= CNT_INIT;
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            bcd_q   <= acc_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench: a decimal reference model queues expected results and
// done times; a negedge monitor pops them whenever the converter raises done.
module tb_binary_to_bcd_seq;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int W2 = 12;
  localparam int D2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start;
  logic [W-1:0]      bin;
  logic              busy;
  logic              done;
  logic [4*D-1:0]    bcd;

  logic              start2;
  logic [W2-1:0]     bin2;
  logic              busy2;
  logic              done2;
  logic [4*D2-1:0]   bcd2;

  binary_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  binary_to_bcd_seq #(.WIDTH(W2), .DIGITS(D2)) dut_wide (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2)
  );

  typedef struct {
    logic [4*D-1:0] bcd;
    int             done_edge;
    int             gen;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass    = 0;
  int   n_tot     = 0;
  int   edge_n    = 0;
  int   gen       = 0;
  int   next_idle = 0;
  int   rst_edge  = -1;

  // Decimal digits by repeated division, packed one nibble per digit.
  function automatic logic [63:0] to_bcd(input int unsigned v);
    logic [63:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 16; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] expv);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Reference model: one conversion in flight, accepted only once idle.
  initial begin
    logic [63:0] t;
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
        gen++;
        rst_edge  = edge_n;
        next_idle = edge_n + 1;
      end else if (start && edge_n >= next_idle) begin
        t = to_bcd(32'(bin));
        exp_q.push_back('{bcd: t[4*D-1:0], done_edge: edge_n + W, gen: gen});
        next_idle = edge_n + W + 1;
      end
    end
  end

  // Monitor.
  initial begin
    logic [4*D-1:0] held;
    exp_t           e;
    bit             exp_busy;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_edge == edge_n) held = '0;
      while (exp_q.size() > 0 && exp_q[0].gen != gen) void'(exp_q.pop_front());
      if (done) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_done", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check(edge_n == e.done_edge, "done_edge", 64'(edge_n), 64'(e.done_edge));
          check(bcd == e.bcd, "done_bcd", 64'(bcd), 64'(e.bcd));
          held = e.bcd;
        end
      end else if (exp_q.size() > 0 && edge_n >= exp_q[0].done_edge) begin
        check(1'b0, "missing_done", 64'(0), 64'(1));
        held = exp_q[0].bcd;
        void'(exp_q.pop_front());
      end
      exp_busy = (exp_q.size() > 0) && (edge_n < exp_q[0].done_edge);
      check(busy == exp_busy, "busy", 64'(busy), 64'(exp_busy));
      check(bcd == held, "bcd_hold", 64'(bcd), 64'(held));
    end
  end

  task automatic pulse(input logic [W-1:0] v);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic conv_wide(input logic [W2-1:0] v);
    logic [63:0] t;
    int          n;
    t      = to_bcd(32'(v));
    start2 = 1'b1;
    bin2   = v;
    @(negedge clk);
    start2 = 1'b0;
    bin2   = ~v;
    n      = 1;
    while (!done2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(n == W2 + 1, "wide_latency", 64'(n), 64'(W2 + 1));
    check(bcd2 == t[4*D2-1:0], "wide_bcd", 64'(bcd2), t[4*D2-1:0]);
    @(negedge clk);
    check(done2 == 1'b0, "wide_done_single", 64'(done2), 64'(0));
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin    = '0;
    start2 = 1'b0;
    bin2   = '0;
    wait_cyc(2);
    check(busy === 1'b0 && done === 1'b0 && bcd === '0, "reset_state",
          64'({busy, done, bcd}), 64'(0));
    rst_n = 1'b1;

    pulse(8'd255);  wait_cyc(W + 1);
    pulse(8'd0);    wait_cyc(W + 1);
    pulse(8'd99);   wait_cyc(W + 1);

    // Second start while busy must be ignored.
    pulse(8'd200);  wait_cyc(2);
    pulse(8'd7);    wait_cyc(W + 1);

    // Abort mid-conversion, then a clean rerun.
    pulse(8'd128);  wait_cyc(3);
    rst_n = 1'b0;   wait_cyc(1);
    rst_n = 1'b1;   wait_cyc(W + 2);
    pulse(8'd128);  wait_cyc(W + 1);

    // start held high: accepts on consecutive idle cycles.
    start = 1'b1;
    bin   = 8'd42;
    @(negedge clk);
    bin   = 8'd57;
    wait_cyc(W + 1);
    start = 1'b0;
    wait_cyc(W + 2);

    // Exhaustive sweep, back-to-back on the done cycle.
    for (int v = 0; v < 256; v++) begin
      pulse(8'(v));
      wait_cyc(W);
    end
    wait_cyc(2);

    // Random starts, operand churn and occasional resets.
    repeat (400) begin
      start = ($urandom_range(0, 3) != 0);
      bin   = 8'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 49) != 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;

    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'(0));

    conv_wide(12'd4095);
    conv_wide(12'd0);
    conv_wide(12'd1000);
    repeat (5) conv_wide(12'($urandom_range(0, 4095)));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
